// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: pre-decode class encoding and opcode field constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decode_queue_pkg;

   // Coarse instruction class produced by pre-decode and carried with each queue entry.
   typedef enum logic [3:0] {
      CLS_INVALID = 4'd0,
      CLS_ALU3R   = 4'd1,
      CLS_ALUI5   = 4'd2,
      CLS_ALUSI12 = 4'd3,
      CLS_SI20    = 4'd4,
      CLS_BRANCH  = 4'd5,
      CLS_JUMP    = 4'd6,
      CLS_LOAD    = 4'd7,
      CLS_STORE   = 4'd8
   } inst_class_e;

   // Opcode field values used by pre-decode.
   localparam logic [11:0] OPC12_ALUI5   = 12'h004;   // inst[31:20]
   localparam logic [2:0]  ALUI5_SUB     = 3'b001;    // inst[17:15]
   localparam logic [6:0]  OPC7_ALUSI12  = 7'b0000001; // inst[31:25]
   localparam logic [3:0]  OPC4_SI20     = 4'b0001;   // inst[31:28]
   localparam logic [1:0]  OPC2_BRJ      = 2'b01;     // inst[31:30]
   localparam logic [2:0]  OPC3_MEM      = 3'b001;    // inst[31:29]
   localparam logic [4:0]  MEM_STORE     = 5'b01001;  // inst[28:24]

   // Control-transfer minor opcodes in inst[29:26]; jumps and branches are contiguous ranges.
   localparam logic [3:0]  BR_JIRL = 4'h3;
   localparam logic [3:0]  BR_B    = 4'h4;
   localparam logic [3:0]  BR_BL   = 4'h5;
   localparam logic [3:0]  BR_BEQ  = 4'h6;
   localparam logic [3:0]  BR_BGEU = 4'hB;

endpackage

// File: rtl/decode_queue_predecode.sv
// Pure combinational pre-decode of one instruction into a coarse class.
// Latency: 0 cycles. Backpressure: none (no state).
// Ports: inst_i (instruction, INST_W >= 32), cls_o (class, first match in priority order).
module inst_predecode
   import decode_queue_pkg::*;
#(
   parameter int INST_W = 32
) (
   input  logic [INST_W-1:0] inst_i,
   output inst_class_e       cls_o
);

   logic [3:0] br_op;
   logic       unused_bits;

   assign br_op       = inst_i[29:26];
   // Low-order operand bits do not affect the class.
   assign unused_bits = ^inst_i;

   always_comb begin
      cls_o = CLS_INVALID;
      if (inst_i[31:22] == 10'd0 && (inst_i[21] | inst_i[20])) begin
         cls_o = CLS_ALU3R;
      end else if (inst_i[31:20] == OPC12_ALUI5 && inst_i[17:15] == ALUI5_SUB) begin
         cls_o = CLS_ALUI5;
      end else if (inst_i[31:25] == OPC7_ALUSI12) begin
         cls_o = CLS_ALUSI12;
      end else if (inst_i[31:28] == OPC4_SI20) begin
         cls_o = CLS_SI20;
      end else if (inst_i[31:30] == OPC2_BRJ && br_op >= BR_BEQ && br_op <= BR_BGEU) begin
         cls_o = CLS_BRANCH;
      end else if (inst_i[31:30] == OPC2_BRJ && br_op >= BR_JIRL && br_op <= BR_BL) begin
         cls_o = CLS_JUMP;
      end else if (inst_i[31:29] == OPC3_MEM) begin
         cls_o = (inst_i[28:24] == MEM_STORE) ? CLS_STORE : CLS_LOAD;
      end
   end

endmodule

// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue; pre-decodes class at enqueue and stores it with the entry.
// Latency: 1 cycle enqueue to out_valid (no bypass); head fields are combinational from storage.
// Backpressure: in_ready = not full, independent of out_ready/flush; flush empties on next edge.
// Ports: in_* fetch side (valid/ready), out_* decode side (valid/ready), flush redirect, count occupancy.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int INST_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [INST_W-1:0]          in_inst,
   input  logic [ADDR_W-1:0]          in_pc,
   input  logic                       in_pred_taken,
   input  logic [ADDR_W-1:0]          in_pred_addr,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INST_W-1:0]          out_inst,
   output logic [ADDR_W-1:0]          out_pc,
   output logic                       out_pred_taken,
   output logic [ADDR_W-1:0]          out_pred_addr,
   output logic [3:0]                 out_class,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
      logic              pred_taken;
      logic [ADDR_W-1:0] pred_addr;
      inst_class_e       cls;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          entry_d;
   inst_class_e     in_cls;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            enq, deq;

   inst_predecode #(.INST_W(INST_W)) u_predecode (
      .inst_i (in_inst),
      .cls_o  (in_cls)
   );

   assign in_ready  = (count_q < DEPTH_C);
   assign out_valid = (count_q != '0);
   assign enq       = in_valid && in_ready && !flush;
   assign deq       = out_valid && out_ready && !flush;

   assign entry_d = '{inst: in_inst, pc: in_pc, pred_taken: in_pred_taken,
                      pred_addr: in_pred_addr, cls: in_cls};

   // Pointers are exactly log2(DEPTH) bits, so +1 wraps DEPTH-1 -> 0 for free.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) tail_d = tail_q + PW'(1);
         if (deq) head_d = head_q + PW'(1);
         case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage is deliberately unreset; out_valid qualifies the head fields.
   always_ff @(posedge clk) begin
      if (enq) mem_q[tail_q] <= entry_d;
   end

   assign out_inst       = mem_q[head_q].inst;
   assign out_pc         = mem_q[head_q].pc;
   assign out_pred_taken = mem_q[head_q].pred_taken;
   assign out_pred_addr  = mem_q[head_q].pred_addr;
   assign out_class      = mem_q[head_q].cls;
   assign count          = count_q;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        in_pred_taken;
   logic [31:0] in_pred_addr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_pred_taken;
   logic [31:0] out_pred_addr;
   logic [3:0]  out_class;
   logic [2:0]  count;

   decode_queue #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_inst        (in_inst),
      .in_pc          (in_pc),
      .in_pred_taken  (in_pred_taken),
      .in_pred_addr   (in_pred_addr),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .out_pred_taken (out_pred_taken),
      .out_pred_addr  (out_pred_addr),
      .out_class      (out_class),
      .count          (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pt;
      logic [31:0] pa;
      logic [3:0]  cls;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   checks   = 0;
   int   failures = 0;

   // Reference classification written from the 6-bit major opcode view.
   function automatic logic [3:0] ref_class(input logic [31:0] i);
      logic [5:0] op6;
      op6 = i[31:26];
      if (i[31:22] == 10'h000 && i[21:20] != 2'b00)            return 4'd1;
      if (i[31:20] == 12'h004 && i[17:15] == 3'b001)           return 4'd2;
      if (i[31:25] == 7'h01)                                    return 4'd3;
      if (i[31:28] == 4'h1)                                     return 4'd4;
      if (op6 >= 6'h16 && op6 <= 6'h1b)                         return 4'd5;
      if (op6 >= 6'h13 && op6 <= 6'h15)                         return 4'd6;
      if (i[31:29] == 3'b001 && i[28:24] == 5'b01001)           return 4'd8;
      if (i[31:29] == 3'b001)                                   return 4'd7;
      return 4'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
      chk({tag, "_in_ready"},  32'(in_ready),  32'(sb.size() < DEPTH));
      chk({tag, "_count"},     32'(count),     32'(sb.size()));
      if (sb.size() != 0) begin
         chk({tag, "_inst"},  out_inst,              sb[0].inst);
         chk({tag, "_pc"},    out_pc,                sb[0].pc);
         chk({tag, "_pt"},    32'(out_pred_taken),   32'(sb[0].pt));
         chk({tag, "_pa"},    out_pred_addr,         sb[0].pa);
         chk({tag, "_class"}, 32'(out_class),        32'(sb[0].cls));
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                        input bit rdy, input bit fl);
      in_valid      = v;
      in_inst       = inst;
      in_pc         = pc;
      in_pred_taken = pc[2];
      in_pred_addr  = pc + 32'h100;
      out_ready     = rdy;
      flush         = fl;
      cur.inst = inst;
      cur.pc   = pc;
      cur.pt   = pc[2];
      cur.pa   = pc + 32'h100;
      cur.cls  = ref_class(inst);
   endtask

   // Advance one clock; the scoreboard follows the queue rules on what was driven.
   task automatic tick(output bit acc);
      bit enq, deq;
      enq = in_valid && (sb.size() < DEPTH) && !flush;
      deq = (sb.size() != 0) && out_ready && !flush;
      @(posedge clk);
      #1;
      if (flush) begin
         sb.delete();
      end else begin
         if (deq) void'(sb.pop_front());
         if (enq) sb.push_back(cur);
      end
      acc = enq;
   endtask

   logic [31:0] insts [9];

   initial begin
      bit acc;
      int sent;
      int cyc;

      insts[0] = 32'h00100000; // ALU3R
      insts[1] = 32'h00408000; // ALUI5
      insts[2] = 32'h02800421; // ALUSI12
      insts[3] = 32'h14000000; // SI20
      insts[4] = 32'h58000000; // BRANCH (beq)
      insts[5] = 32'h50000000; // JUMP (b)
      insts[6] = 32'h28800000; // LOAD
      insts[7] = 32'h29800000; // STORE
      insts[8] = 32'h00000000; // INVALID (no source bits)

      rst_n = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #3 rst_n = 1'b0;
      #1 check_state("reset");
      chk("reset_in_ready_const", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // First enqueue into an empty queue: visible exactly one cycle later.
      drive(1'b1, 32'h02800421, 32'h1c000000, 1'b0, 1'b0);
      check_state("enq0_pre");
      tick(acc);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_state("enq0_post");
      chk("enq0_class", 32'(out_class), 32'd3);
      chk("enq0_pc", out_pc, 32'h1c000000);
      chk("enq0_count", 32'(count), 32'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick(acc);
      check_state("drain0");

      // Five back-to-back offers with decode stalled; the fifth is held.
      sent = 0;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, insts[sent], 32'h1c000100 + 32'(sent * 4), 1'b0, 1'b0);
         check_state("fill");
         tick(acc);
         if (acc) sent++;
      end
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      chk("fill_sent", 32'(sent), 32'd4);

      // Full with both sides active: only the dequeue happens.
      drive(1'b1, insts[sent], 32'h1c000100 + 32'(sent * 4), 1'b1, 1'b0);
      tick(acc);
      chk("full_deq_count", 32'(count), 32'd3);
      chk("full_deq_in_ready", 32'(in_ready), 32'd1);
      check_state("full_deq");
      drive(1'b1, insts[sent], 32'h1c000100 + 32'(sent * 4), 1'b0, 1'b0);
      tick(acc);
      check_state("refill");

      // Drain to two entries, then flush with enqueue and dequeue also requested.
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick(acc);
      tick(acc);
      chk("preflush_count", 32'(count), 32'd2);
      drive(1'b1, insts[7], 32'h1c000200, 1'b1, 1'b1);
      tick(acc);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      check_state("flush");

      // Stream ten entries with random decode stalls, wrapping the pointers.
      sent = 0;
      cyc  = 0;
      while ((sent < 10 || sb.size() != 0) && cyc < 200) begin
         drive(sent < 10, insts[sent % 9], 32'h1c000000 + 32'(sent * 4),
               $urandom_range(0, 1) == 1, 1'b0);
         check_state("stream");
         tick(acc);
         if (acc) sent++;
         cyc++;
      end
      chk("stream_done", 32'(cyc < 200), 32'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_state("stream_end");

      // Asynchronous reset with three entries queued.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, insts[k], 32'h1c000300 + 32'(k * 4), 1'b0, 1'b0);
         tick(acc);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("pre_arst_count", 32'(count), 32'd3);
      #1 rst_n = 1'b0;
      #1;
      sb.delete();
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      drive(1'b1, insts[3], 32'h1c000400, 1'b0, 1'b0);
      tick(acc);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("post_arst_count", 32'(count), 32'd1);
      chk("post_arst_class", 32'(out_class), 32'd4);
      check_state("post_arst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
